alu_mul_seq: RTL and testbench

Iterative shift-add multiply sequencer that borrows the shared 32-bit ALU to implement RV32M `MUL` (low 32 bits of the product). It sits beside the ALU in the execute path. While it owns the ALU, it drives the ALU operands and `alu_control = 3'b000` (ADD) and asserts `alu_grant` so the datapath muxes route its operands in. It accepts one operation at a time through a start/busy/done handshake and holds the result until the next accepted start.

---
 rtl/alu_mul_seq.sv | 121 ++++++++++++
 tb/tb_alu_mul_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Iterative shift-add RV32M MUL sequencer that borrows the shared ALU for its adds.
// One operation at a time via start/busy/done; result holds until the next accepted start.
module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_grant,
    output logic [31:0] alu_src_a,
    output logic [31:0] alu_src_b,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  count;
    logic [31:0] result_q;
    logic [31:0] acc_iter;
    logic        last_iter;
    logic        early_stop;

    // acc_iter is the accumulator after this cycle's iteration; when early_stop holds
    // mplier is zero, so acc_iter equals acc and no add is folded in.
    always_comb begin
        acc_iter   = mplier[0] ? alu_result : acc;
        last_iter  = (count == 6'd31);
        early_stop = EARLY_EXIT && (mplier == 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_iter || early_stop) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, one shift-add per RUN edge, latch result on exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= 32'd0;
            mcand    <= 32'd0;
            mplier   <= 32'd0;
            count    <= 6'd0;
            result_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= 32'd0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        count  <= 6'd0;
                    end
                end
                RUN: begin
                    if (early_stop) begin
                        result_q <= acc;
                    end else begin
                        acc    <= acc_iter;
                        mcand  <= {mcand[30:0], 1'b0};
                        mplier <= {1'b0, mplier[31:1]};
                        count  <= count + 6'd1;
                        if (last_iter) begin
                            result_q <= acc_iter;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign alu_grant   = (state == RUN);
    assign result      = result_q;
    assign alu_src_a   = acc;
    assign alu_src_b   = mcand;
    assign alu_control = 3'b000;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: one instance without and one with early exit, each checked
// every cycle against a latency/product model, plus directed hand-computed cases.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start [2];
    logic [31:0] opA [2];
    logic [31:0] opB [2];
    logic        busy [2];
    logic        done [2];
    logic [31:0] result [2];
    logic        aluGrant [2];
    logic [31:0] aluSrcA [2];
    logic [31:0] aluSrcB [2];
    logic [2:0]  aluControl [2];
    logic [31:0] aluResult [2];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Shared ALU stand-in: a plain combinational adder per instance.
    assign aluResult[0] = aluSrcA[0] + aluSrcB[0];
    assign aluResult[1] = aluSrcA[1] + aluSrcB[1];

    alu_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .op_a(opA[0]), .op_b(opB[0]),
        .busy(busy[0]), .done(done[0]), .result(result[0]), .alu_grant(aluGrant[0]),
        .alu_src_a(aluSrcA[0]), .alu_src_b(aluSrcB[0]), .alu_control(aluControl[0]),
        .alu_result(aluResult[0])
    );

    alu_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .op_a(opA[1]), .op_b(opB[1]),
        .busy(busy[1]), .done(done[1]), .result(result[1]), .alu_grant(aluGrant[1]),
        .alu_src_a(aluSrcA[1]), .alu_src_b(aluSrcB[1]), .alu_control(aluControl[1]),
        .alu_result(aluResult[1])
    );

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Edges from acceptance to entering DONE.
    function automatic int latencyOf(bit early, logic [31:0] b);
        int hi;
        if (!early) return 32;
        if (b == 32'd0) return 1;
        hi = 0;
        for (int j = 0; j < 32; j++) begin
            if (b[j]) hi = j;
        end
        return (hi + 2 > 32) ? 32 : hi + 2;
    endfunction

    // Model: each accepted op is an (accept edge, latency, product) record.
    int          cyc = 0;
    bit          active [2];
    bit          fresh [2];
    int          kEdge [2];
    int          lat [2];
    logic [31:0] prod [2];
    logic [31:0] expRes [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                active[i] = 1'b0;
                fresh[i]  = 1'b1;
                expRes[i] = 32'd0;
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (active[i] && cyc == kEdge[i] + lat[i]) expRes[i] = prod[i];
                if ((!active[i] || cyc - 1 > kEdge[i] + lat[i]) && start[i]) begin
                    active[i] = 1'b1;
                    fresh[i]  = 1'b0;
                    kEdge[i]  = cyc;
                    lat[i]    = latencyOf(i == 1, opB[i]);
                    prod[i]   = opA[i] * opB[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("busy%0d", i), {31'd0, busy[i]},
                        {31'd0, active[i] && cyc <= kEdge[i] + lat[i]});
            checkOutput($sformatf("done%0d", i), {31'd0, done[i]},
                        {31'd0, active[i] && cyc == kEdge[i] + lat[i]});
            checkOutput($sformatf("grant%0d", i), {31'd0, aluGrant[i]},
                        {31'd0, active[i] && cyc < kEdge[i] + lat[i]});
            checkOutput($sformatf("result%0d", i), result[i], expRes[i]);
            checkOutput($sformatf("aluControl%0d", i), {29'd0, aluControl[i]}, 32'd0);
            if (fresh[i]) begin
                checkOutput($sformatf("srcAFresh%0d", i), aluSrcA[i], 32'd0);
                checkOutput($sformatf("srcBFresh%0d", i), aluSrcB[i], 32'd0);
            end
        end
    end

    task automatic applyStimulus(int i, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        start[i] = 1'b1;
        opA[i]   = a;
        opB[i]   = b;
        @(posedge clk);
    endtask

    // Called right after the accept edge; n counts edges past acceptance.
    task automatic observeOp(int i, bit holdStart, output int doneAt, output int busyC,
                             output int grantC, output logic [31:0] res);
        int n;
        n = 0;
        doneAt = -1;
        busyC = 0;
        grantC = 0;
        res = 32'hDEAD_BEEF;
        @(negedge clk);
        if (holdStart) begin
            opA[i] = 32'd5;
            opB[i] = 32'd6;
        end else begin
            start[i] = 1'b0;
        end
        while (busy[i] && n < 100) begin
            busyC += 1;
            if (aluGrant[i]) grantC += 1;
            if (done[i] && doneAt < 0) begin
                doneAt = n;
                res = result[i];
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic directedOp(string tag, int i, logic [31:0] a, logic [31:0] b,
                              logic [31:0] expR, int expDoneAt, int expBusy, int expGrant);
        int doneAt, busyC, grantC;
        logic [31:0] res;
        applyStimulus(i, a, b);
        observeOp(i, 1'b0, doneAt, busyC, grantC, res);
        checkOutput({tag, "_doneAt"}, doneAt, expDoneAt);
        checkOutput({tag, "_result"}, res, expR);
        checkOutput({tag, "_busyCycles"}, busyC, expBusy);
        checkOutput({tag, "_grantCycles"}, grantC, expGrant);
    endtask

    initial begin
        int doneAt, busyC, grantC, doneSeen;
        logic [31:0] res;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            opA[i]   = 32'd0;
            opB[i]   = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("rstBusy", {31'd0, busy[i]}, 32'd0);
            checkOutput("rstResult", result[i], 32'd0);
            checkOutput("rstSrcA", aluSrcA[i], 32'd0);
        end
        reset = 1'b0;

        directedOp("mul3x5", 0, 32'd3, 32'd5, 32'd15, 32, 33, 32);
        directedOp("mulAllOnes", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 33, 32);
        directedOp("mulNeg7x6", 0, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 32, 33, 32);
        directedOp("mulNeg7x6Early", 1, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 4, 5, 4);
        directedOp("mul7x0Early", 1, 32'd7, 32'd0, 32'd0, 1, 2, 1);
        directedOp("mulTopBitEarly", 1, 32'd3, 32'h8000_0000, 32'h8000_0000, 32, 33, 32);

        // 9*4 with start held high and new operands through RUN/DONE.
        applyStimulus(1, 32'd9, 32'd4);
        observeOp(1, 1'b1, doneAt, busyC, grantC, res);
        checkOutput("hold_doneAt", doneAt, 4);
        checkOutput("hold_result", res, 32'd36);
        checkOutput("hold_idleGap", {31'd0, busy[1]}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("hold_acceptFirstIdle", {31'd0, busy[1]}, 32'd1);
        observeOp(1, 1'b0, doneAt, busyC, grantC, res);
        checkOutput("hold_nextResult", res, 32'd30);
        checkOutput("hold_nextDoneAt", doneAt, 4);

        // Asynchronous reset in the middle of RUN.
        applyStimulus(0, 32'd3, 32'd5);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midRst_busy", {31'd0, busy[0]}, 32'd0);
        checkOutput("midRst_done", {31'd0, done[0]}, 32'd0);
        checkOutput("midRst_grant", {31'd0, aluGrant[0]}, 32'd0);
        checkOutput("midRst_result", result[0], 32'd0);
        checkOutput("midRst_srcA", aluSrcA[0], 32'd0);
        checkOutput("midRst_srcB", aluSrcB[0], 32'd0);
        checkOutput("midRst_control", {29'd0, aluControl[0]}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done[0]) doneSeen++;
        end
        checkOutput("midRst_noDone", doneSeen, 0);
        directedOp("mul2x2", 0, 32'd2, 32'd2, 32'd4, 32, 33, 32);

        // Random traffic: start toggles freely, including while busy.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                start[i] = ($urandom_range(0, 3) == 0);
                opA[i]   = $urandom;
                case ($urandom_range(0, 3))
                    0: opB[i] = $urandom;
                    1: opB[i] = 32'd0;
                    default: opB[i] = $urandom >> $urandom_range(0, 31);
                endcase
            end
        end
        @(negedge clk);
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
